// File: rtl/mux8_rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// mux8_rr_arbiter_if
// Bundles the requester-side and result-side signals of the 8-way
// round-robin arbitrated data mux.
//   req    [7:0]         per-requester request, bit i = requester i
//   din    [8*WIDTH-1:0] requester i's data on bits [i*WIDTH +: WIDTH]
//   gnt    [7:0]         registered grant, one-hot or zero
//   sel    [2:0]         registered index of the granted requester
//   dout   [WIDTH-1:0]   registered selected data
//   dvalid               dout carries a new transfer this cycle
//   busy                 a grant is in progress
// The master modport is the requester/consumer side; the slave modport is
// the arbiter itself.
// ---------------------------------------------------------------------------
interface mux8_rr_arbiter_if #(
    parameter int WIDTH = 8
);
    logic [7:0]         req;
    logic [8*WIDTH-1:0] din;
    logic [7:0]         gnt;
    logic [2:0]         sel;
    logic [WIDTH-1:0]   dout;
    logic               dvalid;
    logic               busy;

    modport master (
        output req,
        output din,
        input  gnt,
        input  sel,
        input  dout,
        input  dvalid,
        input  busy
    );

    modport slave (
        input  req,
        input  din,
        output gnt,
        output sel,
        output dout,
        output dvalid,
        output busy
    );
endinterface

// File: rtl/mux8_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux8_rr_arbiter
// Eight-requester round-robin arbiter driving an 8-to-1 data mux. A granted
// requester keeps the grant while it keeps requesting, up to MAX_HOLD
// transfers; then the search restarts one position past it, with itself as
// the last candidate. Hand-over between grants happens in a single edge.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    mux8_rr_arbiter_if.slave (req/din in, gnt/sel/dout/dvalid/busy out)
// Parameters:
//   WIDTH     data width of each requester word
//   MAX_HOLD  maximum transfers per grant, 1..255
// ---------------------------------------------------------------------------
module mux8_rr_arbiter #(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mux8_rr_arbiter_if.slave     bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state_reg;
    logic [2:0]       ptr_reg;
    logic [2:0]       sel_reg;
    logic [7:0]       gnt_reg;
    logic [7:0]       cnt_reg;
    logic [WIDTH-1:0] dout_reg;
    logic             dvalid_reg;

    // Split the flat data bus into one word per requester.
    logic [WIDTH-1:0] din_word [8];

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_din_split
            assign din_word[gi] = bus.din[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Returns {found, index} of the first requester at or after start
    // (wrapping modulo 8). Scanning from the far end and overwriting leaves
    // the nearest hit as the final value.
    function automatic logic [3:0] find_winner(input logic [2:0] start,
                                               input logic [7:0] r);
        logic [3:0] result;
        logic [2:0] idx;
        result = 4'b0000;
        for (int j = 7; j >= 0; j--) begin
            idx = start + 3'(j);
            if (r[idx]) begin
                result = {1'b1, idx};
            end
        end
        return result;
    endfunction

    logic [3:0] start_win;
    logic [3:0] rot_win;
    logic [2:0] sel_plus_one;
    logic       xfer;
    logic       hold_done;
    logic       grant_end;

    assign sel_plus_one = sel_reg + 3'd1;
    assign start_win    = find_winner(ptr_reg, bus.req);
    // Searching from sel+1 puts the current owner last, which lets a lone
    // requester be regranted after using up its hold budget.
    assign rot_win      = find_winner(sel_plus_one, bus.req);
    assign xfer         = bus.req[sel_reg];
    assign hold_done    = (cnt_reg == 8'(MAX_HOLD - 1));
    assign grant_end    = !xfer || hold_done;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            ptr_reg    <= 3'd0;
            sel_reg    <= 3'd0;
            gnt_reg    <= 8'd0;
            cnt_reg    <= 8'd0;
            dout_reg   <= '0;
            dvalid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    dvalid_reg <= 1'b0;
                    gnt_reg    <= 8'd0;
                    if (start_win[3]) begin
                        state_reg <= GRANT;
                        sel_reg   <= start_win[2:0];
                        gnt_reg   <= 8'd1 << start_win[2:0];
                        cnt_reg   <= 8'd0;
                    end
                end

                GRANT: begin
                    if (xfer) begin
                        dout_reg   <= din_word[sel_reg];
                        dvalid_reg <= 1'b1;
                        cnt_reg    <= cnt_reg + 8'd1;
                    end else begin
                        dvalid_reg <= 1'b0;
                    end

                    // Grant end overrides the counter increment above: the
                    // next owner (possibly the same one) starts from zero.
                    if (grant_end) begin
                        ptr_reg <= sel_plus_one;
                        cnt_reg <= 8'd0;
                        if (rot_win[3]) begin
                            sel_reg <= rot_win[2:0];
                            gnt_reg <= 8'd1 << rot_win[2:0];
                        end else begin
                            state_reg <= IDLE;
                            gnt_reg   <= 8'd0;
                        end
                    end
                end

                default: begin
                    state_reg <= IDLE;
                    gnt_reg   <= 8'd0;
                end
            endcase
        end
    end

    assign bus.gnt    = gnt_reg;
    assign bus.sel    = sel_reg;
    assign bus.dout   = dout_reg;
    assign bus.dvalid = dvalid_reg;
    assign bus.busy   = (state_reg == GRANT);

endmodule
